cache_mem_arbiter: RTL



---
 rtl/cache_mem_arbiter_if.sv | 52 +++++
 rtl/cache_mem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - bus bundle between the I/D requesters, the arbiter and the memory port
//
// Purpose: groups the I-side, D-side and memory-port signals of cache_mem_arbiter.
// Ports (signals):
//   im_req/im_addr                  -> arbiter   I-side read-burst request and miss address
//   im_gnt/im_rvalid/im_rdata/im_done <- arbiter I-side grant, read beats, completion
//   dm_req/dm_we/dm_addr/dm_wdata   -> arbiter   D-side request (write or read burst)
//   dm_gnt/dm_rvalid/dm_rdata/dm_done <- arbiter D-side grant, read beats, completion
//   mem_cs/mem_we/mem_addr/mem_wdata <- arbiter  memory beat strobe, write enable, address, data
//   mem_rdata/mem_ready             -> arbiter   memory read data and beat-complete
// Modports: master = arbiter view, slave = requesters + memory view.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;
    logic              im_done;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output im_gnt, im_rvalid, im_rdata, im_done,
        output dm_gnt, dm_rvalid, dm_rdata, dm_done,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  im_gnt, im_rvalid, im_rdata, im_done,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_done,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin sharing of one memory port between I-cache refill and D-cache
//
// Purpose: runs one memory transaction at a time, either a BURST_LEN-beat aligned read
// burst or a single-beat write, for the I side or the D side. Simultaneous requests are
// resolved round-robin against the previous owner. Read beats are steered to the owner.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; aborts any transaction without a done pulse
//   bus  - cache_mem_arbiter_if.master: I/D request/grant/beat/done and memory port
module cache_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_mem_arbiter_if.master    bus
);
    localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int ALIGN_BITS = $clog2(BURST_LEN * 4);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              im_gnt_q, im_gnt_d;
    logic              dm_gnt_q, dm_gnt_d;

    logic              busy;
    logic              beat_fire;
    logic              last_beat;
    logic              pick;
    logic [ADDR_W-1:0] beat_off;

    assign busy      = (state_q == ST_BUSY);
    assign beat_fire = busy && bus.mem_ready;
    // A write is always a single beat; a read ends on its last burst beat.
    assign last_beat = we_q || (beat_cnt_q == LAST_BEAT);
    assign beat_off  = {{(ADDR_W-CNT_W-2){1'b0}}, beat_cnt_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        im_gnt_d     = 1'b0;
        dm_gnt_d     = 1'b0;
        pick         = OWN_I;

        case (state_q)
            ST_IDLE: begin
                if (bus.im_req || bus.dm_req) begin
                    // On a tie the side that did not own the last transaction wins.
                    pick       = (bus.im_req && bus.dm_req) ? ~last_owner_q : bus.dm_req;
                    owner_d    = pick;
                    addr_d     = (pick == OWN_D) ? bus.dm_addr : bus.im_addr;
                    we_d       = (pick == OWN_D) && bus.dm_we;
                    wdata_d    = (pick == OWN_D) ? bus.dm_wdata : '0;
                    beat_cnt_d = '0;
                    im_gnt_d   = (pick == OWN_I);
                    dm_gnt_d   = (pick == OWN_D);
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (beat_fire) begin
                    if (!we_q) begin
                        // BURST_LEN is a power of two, so the counter wraps to 0 by itself.
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (last_beat) begin
                        last_owner_d = owner_q;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            im_gnt_q     <= 1'b0;
            dm_gnt_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            im_gnt_q     <= im_gnt_d;
            dm_gnt_q     <= dm_gnt_d;
        end
    end

    // Memory port is driven only while BUSY so that IDLE/DONE present all zeros.
    assign bus.mem_cs    = busy;
    assign bus.mem_we    = busy && we_q;
    assign bus.mem_addr  = !busy ? '0 : (we_q ? addr_q : ((addr_q & ALIGN_MASK) + beat_off));
    assign bus.mem_wdata = busy ? wdata_q : '0;

    assign bus.im_gnt    = im_gnt_q;
    assign bus.im_rvalid = beat_fire && !we_q && (owner_q == OWN_I);
    assign bus.im_rdata  = bus.im_rvalid ? bus.mem_rdata : '0;
    assign bus.im_done   = beat_fire && last_beat && (owner_q == OWN_I);

    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.dm_rvalid = beat_fire && !we_q && (owner_q == OWN_D);
    assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
    assign bus.dm_done   = beat_fire && last_beat && (owner_q == OWN_D);
endmodule
